// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- RV32I instruction fetch stage.
//
// Fetches each 32-bit instruction as four little-endian bytes over the
// byte-wide unified memory port, assembles the word and hands it, together
// with its PC, to decode through a valid/stall output register. Handles
// decode back-pressure, memory port arbitration and branch/jump redirects.
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   stall_i          decode cannot accept; output register holds
//   branch_flag_i    redirect request from execute
//   branch_target_i  redirect PC
//   mem_ready_i      arbiter grants the memory port this cycle
//   mem_din_i        read byte for the address accepted last cycle
//   mem_a_o          byte address (combinational from registers)
//   mem_wr_o         always 0, the fetch port only reads
//   if_pc_o          PC of the presented instruction
//   if_inst_o        assembled instruction
//   if_valid_o       if_pc_o/if_inst_o hold an unconsumed instruction
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        mem_ready_i,
  input  logic [7:0]  mem_din_i,
  output logic [31:0] mem_a_o,
  output logic        mem_wr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DRAIN = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fpc_q, fpc_d;
  logic [1:0]      idx_q, idx_d;
  logic            pend_q, pend_d;
  logic [1:0]      pidx_q, pidx_d;
  logic [3:0][7:0] b_q, b_d;
  logic            valid_q, valid_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;

  logic            load_s;
  logic [31:0]     load_inst_s;

  // In DRAIN/FULL the port idles on the last byte's address.
  assign mem_a_o    = (state_q == S_FETCH) ? (fpc_q + {30'd0, idx_q}) : (fpc_q + 32'd3);
  assign mem_wr_o   = 1'b0;
  assign if_pc_o    = pc_q;
  assign if_inst_o  = inst_q;
  assign if_valid_o = valid_q;

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    idx_d       = idx_q;
    pend_d      = 1'b0;
    pidx_d      = pidx_q;
    b_d         = b_q;
    valid_d     = valid_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    load_s      = 1'b0;
    load_inst_s = inst_q;

    if (branch_flag_i) begin
      // Redirect: the in-flight byte is dropped and no load happens.
      fpc_d   = branch_target_i;
      idx_d   = 2'd0;
      pend_d  = 1'b0;
      state_d = S_FETCH;
      valid_d = 1'b0;
    end else begin
      if (pend_q) begin
        b_d[pidx_q] = mem_din_i;
      end else begin
        b_d = b_q;
      end

      case (state_q)
        S_FETCH: begin
          if (mem_ready_i) begin
            pend_d = 1'b1;
            pidx_d = idx_q;
            idx_d  = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_d = S_DRAIN;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            pend_d = 1'b0;
          end
        end
        S_DRAIN: begin
          // Byte 3 is on mem_din_i now; bypass it straight into the output.
          if (!valid_q || !stall_i) begin
            load_s      = 1'b1;
            load_inst_s = {mem_din_i, b_q[2], b_q[1], b_q[0]};
            state_d     = S_FETCH;
          end else begin
            state_d = S_FULL;
          end
        end
        S_FULL: begin
          if (!stall_i) begin
            load_s      = 1'b1;
            load_inst_s = b_q;
            state_d     = S_FETCH;
          end else begin
            state_d = S_FULL;
          end
        end
        default: begin
          state_d = S_FETCH;
          idx_d   = 2'd0;
        end
      endcase

      if (load_s) begin
        valid_d = 1'b1;
        pc_d    = fpc_q;
        inst_d  = load_inst_s;
        fpc_d   = fpc_q + 32'd4;
        idx_d   = 2'd0;
      end else if (valid_q && !stall_i) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      fpc_q   <= RESET_PC;
      idx_q   <= 2'd0;
      pend_q  <= 1'b0;
      pidx_q  <= 2'd0;
      b_q     <= '0;
      valid_q <= 1'b0;
      pc_q    <= 32'd0;
      inst_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      pidx_q  <= pidx_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        mem_ready_i;
  logic [7:0]  mem_din_i;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .mem_ready_i     (mem_ready_i),
    .mem_din_i       (mem_din_i),
    .mem_a_o         (mem_a_o),
    .mem_wr_o        (mem_wr_o),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .if_valid_o      (if_valid_o)
  );

  int errors = 0;
  int checks = 0;

  // 256-byte memory image; addresses alias on their low byte.
  logic [7:0]  mem [256];
  logic [31:0] prev_addr;

  // Reference model: a fetch is "how many of the 4 byte reads were granted"
  // plus the held output; the instruction is read straight from memory.
  bit          m_known;
  logic [31:0] m_fpc;
  logic [2:0]  m_issued;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_inst;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] ak;
    w = 32'd0;
    for (int k = 0; k < 4; k++) begin
      ak = a + k;
      w[8*k +: 8] = mem[ak[7:0]];
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance both.
  task automatic cyc(input logic st, input logic br, input logic [31:0] tgt,
                     input logic rdy, input logic rs);
    bit ld;
    stall_i         = st;
    branch_flag_i   = br;
    branch_target_i = tgt;
    mem_ready_i     = rdy;
    rst             = rs;
    mem_din_i       = mem[prev_addr[7:0]];
    #1;
    if (m_known) begin
      chk("addr", mem_a_o, (m_issued < 3'd4) ? (m_fpc + {29'd0, m_issued}) : (m_fpc + 32'd3));
      chk("valid", {31'd0, if_valid_o}, {31'd0, m_valid});
      chk("pc", if_pc_o, m_pc);
      chk("inst", if_inst_o, m_inst);
      chk("wr", {31'd0, mem_wr_o}, 32'd0);
    end
    prev_addr = mem_a_o;
    ld = 1'b0;
    if (rs) begin
      m_known  = 1'b1;
      m_fpc    = 32'd0;
      m_issued = 3'd0;
      m_valid  = 1'b0;
      m_pc     = 32'd0;
      m_inst   = 32'd0;
    end else if (br) begin
      m_fpc    = tgt;
      m_issued = 3'd0;
      m_valid  = 1'b0;
    end else begin
      if (m_issued == 3'd4) begin
        if (!m_valid || !st) begin
          ld       = 1'b1;
          m_pc     = m_fpc;
          m_inst   = word_at(m_fpc);
          m_fpc    = m_fpc + 32'd4;
          m_issued = 3'd0;
        end
      end else if (rdy) begin
        m_issued = m_issued + 3'd1;
      end
      if (ld) m_valid = 1'b1;
      else if (m_valid && !st) m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    int guard;
    logic st, br, rdy, rs;
    logic [31:0] tgt;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    prev_addr = 32'd0;
    m_known = 1'b0;
    m_fpc = 32'd0; m_issued = 3'd0; m_valid = 1'b0; m_pc = 32'd0; m_inst = 32'd0;

    // Reset, then first fetch from address 0.
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    run(5);
    chk("tp_first_valid", {31'd0, if_valid_o}, 32'd1);
    chk("tp_first_pc", if_pc_o, 32'd0);
    chk("tp_first_inst", if_inst_o, 32'h0010_0513);
    chk("tp_first_addr", mem_a_o, 32'd4);

    // Stall cycles 5..14, release in cycle 15: next word loads with no gap.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("tp_full_pc", if_pc_o, 32'd4);
    chk("tp_full_valid", {31'd0, if_valid_o}, 32'd1);

    // Port withheld for 3 cycles while idx=2.
    run(2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    run(8);

    // Redirect during DRAIN.
    guard = 0;
    while (m_issued != 3'd4 && guard < 20) begin
      run(1);
      guard++;
    end
    chk("drain_reached", {31'd0, (m_issued == 3'd4)}, 32'd1);
    cyc(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
    chk("tp_br_addr", mem_a_o, 32'h0000_0100);
    chk("tp_br_valid", {31'd0, if_valid_o}, 32'd0);
    run(5);
    chk("tp_br_tgt_valid", {31'd0, if_valid_o}, 32'd1);
    chk("tp_br_tgt_pc", if_pc_o, 32'h0000_0100);

    // Redirect together with stall while valid: redirect wins.
    cyc(1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
    chk("tp_br_stall_valid", {31'd0, if_valid_o}, 32'd0);

    // Reset in cycle 2 of a fetch, with other inputs active.
    run(2);
    cyc(1'b1, 1'b1, 32'h0000_0055, 1'b1, 1'b1);
    chk("tp_rst_addr", mem_a_o, 32'd0);
    chk("tp_rst_valid", {31'd0, if_valid_o}, 32'd0);
    chk("tp_rst_inst", if_inst_o, 32'd0);
    run(5);
    chk("tp_rst_refetch", if_inst_o, 32'h0010_0513);

    // PC wrap at the top of the address space.
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    run(5);
    chk("wrap_pc", if_pc_o, 32'hFFFF_FFFC);
    chk("wrap_next_addr", mem_a_o, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      st  = ($urandom_range(0, 99) < 30);
      rdy = ($urandom_range(0, 99) < 75);
      br  = ($urandom_range(0, 99) < 5);
      rs  = ($urandom_range(0, 199) == 0);
      tgt = $urandom;
      cyc(st, br, tgt, rdy, rs);
    end
    run(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage of the RV32I pipeline, directly upstream of the decode stage. Reads each 32-bit instruction as four little-endian bytes through the byte-wide unified memory port, assembles the word and presents it with its PC to decode through a valid/stall output register. Handles stall back-pressure, port arbitration and branch/jump redirects.

## Interface

- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  decode cannot accept; holds the output register.
- branch_flag_i  in  1  redirect request from execute.
- branch_target_i  in  32  redirect PC.
- mem_ready_i  in  1  arbiter grants the memory port this cycle.
- mem_din_i  in  8  read byte for the address accepted in the previous cycle.
- mem_a_o  out  32  byte address.
- mem_wr_o  out  1  constant 0 (read only).
- if_pc_o  out  32  PC of the presented instruction.
- if_inst_o  out  32  assembled instruction.
- if_valid_o  out  1  if_pc_o/if_inst_o hold an unconsumed instruction.

## Operation

- Registers:
  - fpc: fetch PC.
  - idx: 2-bit issue index.
  - pend / pidx: an accepted read is in flight, and its slot.
  - b0..b3: byte buffer.
  - state: FETCH, DRAIN or FULL.
- Reset:
  - fpc=RESET_PC, state=FETCH, idx=0, pend=0, b0..b3=0.
  - if_valid_o=0, if_pc_o=0, if_inst_o=0.
- mem_a_o = fpc+idx in FETCH; fpc+3 in DRAIN/FULL. The address is combinational from registers.
- Issue acceptance:
  - An issue is accepted when state=FETCH and mem_ready_i=1.
  - On acceptance: pend<=1, pidx<=idx, idx<=idx+1.
  - Otherwise pend<=0.
- Byte capture: when pend=1, b[pidx]<=mem_din_i.
- FETCH: when idx=3 is accepted, go to DRAIN. mem_ready_i=0 holds idx and address.
- DRAIN: byte3 arrives this cycle.
  - If the slot is free (if_valid_o=0 or stall_i=0): load outputs with if_inst_o={mem_din_i,b2,b1,b0} and if_pc_o=fpc; set if_valid_o=1, fpc<=fpc+4, idx<=0, go to FETCH.
  - Otherwise latch b3 and go to FULL.
- FULL: when stall_i=0, load outputs with {b3,b2,b1,b0} and fpc; set fpc+=4, go to FETCH.
- Output consumption: when if_valid_o=1 and stall_i=0 and no new load occurs this cycle, if_valid_o<=0.
- Redirect has the highest priority below rst. When branch_flag_i=1:
  - fpc<=branch_target_i, idx<=0, pend<=0, state<=FETCH, if_valid_o<=0.
  - The in-flight byte is discarded.
  - No output load occurs that cycle, even in DRAIN/FULL.
- Target alignment is not checked; fpc increments by 4 with 32-bit wrap (32'hFFFF_FFFC+4=0).

## Timing

- Reset is released in cycle 0 with no stall, mem_ready_i=1 and no branch:
  - Addresses RESET_PC+0..3 are driven in cycles 0–3.
  - Cycle 4 is DRAIN.
  - The first instruction is valid in cycle 5.
- Throughput: one instruction per 5 cycles when unstalled.
- Each cycle with mem_ready_i=0 in FETCH adds one cycle of latency.
- Memory read latency is exactly 1 cycle; mem_din_i is ignored unless pend=1.
- Stall in DRAIN with if_valid_o=1 forces FULL. Fetching resumes the cycle after stall_i falls. The held output is replaced on that same edge, so no bubble is inserted.
- A redirect in cycle t drives branch_target_i on mem_a_o in cycle t+1; the target instruction is valid in cycle t+6.
- rst asserted mid-fetch returns every register to its reset value on the next edge, regardless of other inputs.

## Test plan

- Bytes 0x13,0x05,0x10,0x00 at address 0; release reset -> cycle 5: if_valid_o=1, if_pc_o=0, if_inst_o=32'h00100513; mem_a_o=4 in cycle 5.
- Hold stall_i=1 from cycle 5 to cycle 14 -> if_pc_o=0 held throughout; FSM parks in FULL; the edge ending the first cycle with stall_i=0 loads if_pc_o=4 with no gap.
- Drop mem_ready_i for 3 cycles while idx=2 -> mem_a_o holds fpc+2; if_valid_o is delayed exactly 3 cycles; assembled word is still correct.
- Pulse branch_flag_i with target 0x100 during DRAIN -> no output load; if_valid_o=0; mem_a_o=0x100 next cycle; word from 0x100 valid 6 cycles after the pulse.
- branch_flag_i and stall_i both high with if_valid_o=1 -> if_valid_o=0 next cycle (redirect wins).
- Assert rst in cycle 2 of a fetch -> next cycle: mem_a_o=RESET_PC, if_valid_o=0, outputs 0; the first fetch then completes normally.
